// File: rtl/dffn_pkg.sv
// Shared constants for the 32-bit adder pipeline and its result collector.
package dffn_pkg;

  localparam int DFFN_DATA_W  = 32;
  localparam int DFFN_LATENCY = 11;

  typedef logic [DFFN_DATA_W-1:0] dffn_word_t;

  function automatic logic [15:0] dffn_sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/dffn_sync_fifo.sv
// Synchronous FIFO whose head word is held in a register, so dout never
// depends combinationally on the storage array or on din.
module dffn_sync_fifo
  import dffn_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DFFN_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [$clog2(DEPTH):0]   fill_nxt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_inc_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] head_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  // Accepted push/pop, next occupancy and next head word.
  always_comb begin
    pop_ok_s     = pop & ~empty_r;
    push_ok_s    = push & (~full_r | pop_ok_s);
    rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
    case ({push_ok_s, pop_ok_s})
      2'b10:   fill_nxt_s = fill_r + FILL_W'(1);
      2'b01:   fill_nxt_s = fill_r - FILL_W'(1);
      default: fill_nxt_s = fill_r;
    endcase
    // With a single entry left, a popping push hands din straight to the head.
    if (pop_ok_s) begin
      if (fill_r > FILL_W'(1)) begin
        head_nxt_s = mem_r[rd_ptr_inc_s];
      end else if (push_ok_s) begin
        head_nxt_s = din;
      end else begin
        head_nxt_s = head_r;
      end
    end else if (push_ok_s && empty_r) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Pointers, occupancy flags and the registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      head_r   <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      fill_r  <= fill_nxt_s;
      head_r  <= head_nxt_s;
      empty_r <= (fill_nxt_s == FILL_W'(0));
      full_r  <= (fill_nxt_s == FILL_W'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout     = head_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign fill     = fill_r;
  assign fill_nxt = fill_nxt_s;

endmodule

// File: rtl/dffn_result_collector.sv
// Collects sums from the valid-less adder pipeline into a FIFO with credit flow control.
// Optional pop/accumulate/drop statistics when DFFN_COLLECT_STATS_EN is defined.
module dffn_result_collector
  import dffn_pkg::*;
#(
  parameter int DATA_W  = DFFN_DATA_W,
  parameter int LATENCY = DFFN_LATENCY,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      sum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow
`ifdef DFFN_COLLECT_STATS_EN
  ,
  output logic [31:0]            pop_cnt,
  output logic [DATA_W-1:0]      acc,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int INF_W  = $clog2(LATENCY + 1);
  localparam int SUM_W  = ((FILL_W > INF_W) ? FILL_W : INF_W) + 1;

  logic [LATENCY-1:0] vld_r;
  logic [INF_W-1:0]   inflight_r;
  logic [INF_W-1:0]   inflight_nxt_s;
  logic [SUM_W-1:0]   credit_sum_s;
  logic               in_ready_r;
  logic               overflow_r;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic               empty_s;
  logic               full_s;
  logic [FILL_W-1:0]  fill_s;
  logic [FILL_W-1:0]  fill_nxt_s;

  dffn_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .din      (sum_in),
    .pop      (out_ready),
    .dout     (out_data),
    .empty    (empty_s),
    .full     (full_s),
    .fill     (fill_s),
    .fill_nxt (fill_nxt_s)
  );

  // Capture strobe, drop detection and next-cycle credit.
  always_comb begin
    push_s = vld_r[LATENCY-1];
    pop_s  = out_ready & ~empty_s;
    drop_s = push_s & full_s & ~pop_s;
    case ({issue, push_s})
      2'b10:   inflight_nxt_s = inflight_r + INF_W'(1);
      2'b01:   inflight_nxt_s = inflight_r - INF_W'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
    credit_sum_s = SUM_W'(fill_nxt_s) + SUM_W'(inflight_nxt_s);
  end

  // Issue delay line, in-flight counter, registered in_ready and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r      <= '0;
      inflight_r <= '0;
      in_ready_r <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      vld_r      <= {vld_r[LATENCY-2:0], issue};
      inflight_r <= inflight_nxt_s;
      in_ready_r <= (credit_sum_s < SUM_W'(DEPTH));
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = ~empty_s;
  assign fill      = fill_s;
  assign overflow  = overflow_r;

`ifdef DFFN_COLLECT_STATS_EN
  logic [31:0]       pop_cnt_r;
  logic [DATA_W-1:0] acc_r;
  logic [15:0]       drop_cnt_r;

  // Pop count, wrapping sum of popped words and saturating drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt_r  <= 32'd0;
      acc_r      <= '0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (pop_s) begin
        pop_cnt_r <= pop_cnt_r + 32'd1;
        acc_r     <= acc_r + out_data;
      end
      if (drop_s) begin
        drop_cnt_r <= dffn_sat_inc16(drop_cnt_r);
      end
    end
  end

  assign pop_cnt  = pop_cnt_r;
  assign acc      = acc_r;
  assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_dffn_result_collector.sv
// Scoreboard bench for dffn_result_collector; stats checks under DFFN_COLLECT_STATS_EN.
module tb_dffn_result_collector;
  import dffn_pkg::*;

  localparam int DATA_W  = DFFN_DATA_W;
  localparam int LATENCY = DFFN_LATENCY;
  localparam int DEPTH   = 8;
  localparam int FILL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue;
  logic              in_ready;
  logic [DATA_W-1:0] sum_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [FILL_W-1:0] fill;
  logic              overflow;
`ifdef DFFN_COLLECT_STATS_EN
  logic [31:0]       pop_cnt;
  logic [DATA_W-1:0] acc;
  logic [15:0]       drop_cnt;
`endif

  always #5 clk = ~clk;

  dffn_result_collector #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .overflow  (overflow)
`ifdef DFFN_COLLECT_STATS_EN
    ,
    .pop_cnt   (pop_cnt),
    .acc       (acc),
    .drop_cnt  (drop_cnt)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: words scheduled onto sum_in by edge number, expected FIFO contents.
  logic [DATA_W-1:0] cap [int];
  logic [DATA_W-1:0] exp_q [$];
  int                m_fill  = 0;
  bit                m_ovf   = 1'b0;
  bit                m_known = 1'b0;
  logic [31:0]       m_pops  = 32'd0;
  logic [DATA_W-1:0] m_acc   = '0;
  logic [15:0]       m_drops = 16'd0;
  int                ecnt    = 0;

  bit                d_rst   = 1'b1;
  bit                d_issue = 1'b0;
  bit                d_ready = 1'b0;
  logic [DATA_W-1:0] d_val   = '0;

  // Called just after a falling edge: drive, check, update model, advance one edge.
  task automatic cycle();
    logic [DATA_W-1:0] s;
    bit push, pop;
    s = cap.exists(ecnt) ? cap[ecnt] : DATA_W'($urandom);
    rst = d_rst; issue = d_issue; out_ready = d_ready; sum_in = s;
    if (m_known) begin
      check_eq("out_valid", 64'(out_valid), 64'(m_fill > 0));
      check_eq("fill", 64'(fill), 64'(m_fill));
      check_eq("in_ready", 64'(in_ready), 64'((m_fill + cap.num()) < DEPTH));
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      if (m_fill > 0) check_eq("out_data", 64'(out_data), 64'(exp_q[0]));
`ifdef DFFN_COLLECT_STATS_EN
      check_eq("pop_cnt", 64'(pop_cnt), 64'(m_pops));
      check_eq("acc", 64'(acc), 64'(m_acc));
      check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
    end
    if (d_rst) begin
      cap.delete(); exp_q.delete();
      m_fill = 0; m_ovf = 1'b0; m_known = 1'b1;
      m_pops = 32'd0; m_acc = '0; m_drops = 16'd0;
    end else begin
      pop  = (m_fill > 0) && d_ready;
      push = cap.exists(ecnt);
      if (pop) begin
        m_pops = m_pops + 32'd1;
        m_acc  = m_acc + exp_q[0];
        void'(exp_q.pop_front());
      end
      if (push) begin
        if (m_fill == DEPTH && !pop) begin
          m_ovf = 1'b1;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end else begin
          exp_q.push_back(s);
        end
        cap.delete(ecnt);
      end
      m_fill = exp_q.size();
      if (d_issue) cap[ecnt + LATENCY] = d_val;
    end
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    d_issue = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue_word(input logic [DATA_W-1:0] v);
    d_issue = 1'b1; d_val = v;
    cycle();
    d_issue = 1'b0;
  endtask

  initial begin
    int target, start;
    logic [DATA_W-1:0] s6 [5];
    s6[0] = 32'd10; s6[1] = 32'd20; s6[2] = 32'd30; s6[3] = 32'd40; s6[4] = 32'hFFFF_FFF6;
    rst = 1'b1; issue = 1'b0; out_ready = 1'b0; sum_in = '0;
    @(negedge clk);
    d_rst = 1'b1;
    idle(2);
    d_rst = 1'b0;
    check_eq("rst_out_data", 64'(out_data), 64'h0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h1);

    // Single issue, then pop.
    issue_word(32'h0000_1234);
    idle(11);
    check_eq("s1_fill", 64'(fill), 64'd1);
    check_eq("s1_data", 64'(out_data), 64'h1234);
    d_ready = 1'b1; idle(2); d_ready = 1'b0;
    check_eq("s1_fill_popped", 64'(fill), 64'd0);

    // Eight back-to-back issues fill the FIFO exactly.
    for (int i = 1; i <= 8; i++) issue_word(DATA_W'(i));
    check_eq("s2_in_ready", 64'(in_ready), 64'h0);
    idle(11);
    check_eq("s2_fill", 64'(fill), 64'd8);
    check_eq("s2_overflow", 64'(overflow), 64'h0);
    d_ready = 1'b1; idle(10); d_ready = 1'b0;

    // Nine issues: the ninth word is dropped.
    for (int i = 1; i <= 9; i++) issue_word(DATA_W'(i));
    idle(12);
    check_eq("s3_overflow", 64'(overflow), 64'h1);
    check_eq("s3_fill", 64'(fill), 64'd8);
`ifdef DFFN_COLLECT_STATS_EN
    check_eq("s3_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Full FIFO: push and pop on the same edge.
    target = ecnt + LATENCY;
    issue_word(32'hDEAD_BEEF);
    while (ecnt <= target) begin
      d_ready = (ecnt == target);
      cycle();
    end
    d_ready = 1'b0;
    check_eq("s4_fill", 64'(fill), 64'd8);
    d_ready = 1'b1; idle(7);
    check_eq("s4_last", 64'(out_data), 64'hDEAD_BEEF);
    idle(3); d_ready = 1'b0;

    // Reset with three words buffered and four in flight.
    start = ecnt;
    for (int i = 0; i < 7; i++) issue_word(DATA_W'(100 + i));
    idle(start + 14 - ecnt);
    check_eq("s5_pre_fill", 64'(fill), 64'd3);
    d_rst = 1'b1; idle(1); d_rst = 1'b0;
    check_eq("s5_fill", 64'(fill), 64'd0);
    check_eq("s5_out_valid", 64'(out_valid), 64'h0);
    check_eq("s5_in_ready", 64'(in_ready), 64'h1);
    check_eq("s5_overflow", 64'(overflow), 64'h0);
    d_ready = 1'b1; idle(20);
    check_eq("s5_no_ghost", 64'(fill), 64'd0);
    d_ready = 1'b0;

    // Five words whose sum wraps.
    for (int i = 0; i < 5; i++) issue_word(s6[i]);
    idle(11);
    d_ready = 1'b1; idle(7); d_ready = 1'b0;
`ifdef DFFN_COLLECT_STATS_EN
    check_eq("s6_pop_cnt", 64'(pop_cnt), 64'd5);
    check_eq("s6_acc", 64'(acc), 64'd90);
`endif
    check_eq("s6_empty", 64'(out_valid), 64'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dffn_result_collector.md
Name: dffn_result_collector

Overview:
- Downstream stage of the 32-bit, 11-cycle adder pipeline (operands a/b in, sum out).
- The pipeline carries no valid signal. This block tracks which cycles were issued, captures the matching sum_in, and buffers it in a FIFO.
- Results are presented on a ready/valid output.
- Also drives a credit-based in_ready so the issuer never overruns the buffer.

Parameters:
- DATA_W, 32, width of sum_in/out_data.
- LATENCY, 11, edges from operand sampling to valid sum_in.
- DEPTH, 8, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- issue  in  1  high in the cycle a/b are presented to the pipeline
- in_ready  out  1  issuing this cycle is guaranteed not to overflow
- sum_in  in  DATA_W  pipeline sum output
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  DATA_W  FIFO head data
- fill  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset: rst sampled high at an edge clears the delay line, FIFO pointers, fill, inflight and overflow. After that edge: out_valid=0, fill=0, overflow=0, in_ready=1, out_data=0. Reset mid-operation discards all buffered and in-flight results.
- Delay line: LATENCY-bit shift register vld[0..LATENCY-1]; vld[0]<=issue, vld[i]<=vld[i-1].
- Capture:
  - push = vld[LATENCY-1].
  - An issue sampled at edge k writes sum_in into the FIFO at edge k+LATENCY.
  - Back-to-back issues give back-to-back pushes.
- Pop: pop = out_valid & out_ready. out_data is the registered FIFO head. It is stable while out_valid=1 and out_ready=0.
- First-word latency: a push at edge n gives out_valid=1 after edge n (visible the cycle after the push edge). There is no combinational bypass from sum_in.
- Full FIFO:
  - push with no pop drops the word and sets overflow=1 (sticky until rst); fill unchanged.
  - push and pop on the same edge: both take effect, fill unchanged, no drop.
- Empty FIFO: pop cannot occur (out_valid=0). A push alone gives fill=1.
- Pointers: wrap modulo DEPTH. fill counts 0..DEPTH inclusive.
- Credit:
  - inflight = popcount(vld), maintained as a counter: +issue, -push.
  - in_ready = (fill + inflight) < DEPTH.
  - An issue while in_ready=0 is still tracked and may overflow. This is the issuer's error.
- No arithmetic on data; words are passed bit-exact.

Optional Feature:
- Macro: DFFN_COLLECT_STATS_EN.
- With the macro defined:
  - Extra outputs pop_cnt[31:0]: wrapping count of pops.
  - acc[DATA_W-1:0]: wrapping sum of popped out_data, updated at the pop edge.
  - drop_cnt[15:0]: count of dropped words, saturating at 16'hFFFF.
  - All three clear on rst.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package dffn_pkg holds:
  - DFFN_DATA_W=32 and DFFN_LATENCY=11, shared with the adder pipeline so the latency stays consistent.
  - Typedef dffn_word_t = logic [DFFN_DATA_W-1:0].
- Sub-module dffn_sync_fifo (DEPTH, DATA_W): registered-head synchronous FIFO with push/pop/full/empty/fill.
- Delay line, credit counter and overflow logic stay in the top module.

Test Plan:
- Single issue at edge 0, sum_in=32'h0000_1234 held at edge 11 -> out_valid rises after edge 11, out_data=32'h1234, fill=1; with out_ready=1 it pops and fill=0.
- 8 back-to-back issues, out_ready=0, sum_in=1..8 across edges 11..18 -> fill=8, in_ready=0 from the cycle after the 8th issue, overflow=0; draining then yields 1..8 in order.
- 9 issues ignoring in_ready, out_ready=0 -> 9th word (9) is dropped, overflow=1, fill=8. With STATS_EN, drop_cnt=1.
- Full FIFO, out_ready=1 on the same edge as a push of 32'hDEAD_BEEF -> no drop, fill stays 8, DEADBEEF emerges last.
- rst asserted mid-stream with 3 buffered and 4 in flight -> after that edge fill=0, out_valid=0, in_ready=1, overflow=0. The 4 in-flight results are never pushed.
- STATS_EN: pop 5 words 10,20,30,40,0xFFFF_FFF6 -> pop_cnt=5, acc=32'd90 (wrapped).
